// File: rtl/laser_rx_deframer.sv
// Receive deframer for the 4-lane laser link: synchronizes the lanes, finds the start symbol and rebuilds bytes.
// Optional LASER_RX_CHECKSUM_EN adds a trailing XOR check byte that is verified before the stop symbol.
module laser_rx_deframer #(
  parameter int CLKS_PER_SYM  = 8,
  parameter int PAYLOAD_BYTES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] lanes,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_done,
  output logic       frame_error,
  output logic       busy
);

  localparam int SCW = $clog2(CLKS_PER_SYM);
  localparam int NCW = $clog2(2 * PAYLOAD_BYTES + 1);
  localparam logic [SCW-1:0] SYM_LAST  = SCW'(CLKS_PER_SYM - 1);
  localparam logic [SCW-1:0] HALF_LAST = SCW'(CLKS_PER_SYM / 2 - 1);
  localparam logic [NCW-1:0] NIB_LAST  = NCW'(2 * PAYLOAD_BYTES - 1);

`ifdef LASER_RX_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, START, DATA, CHECK, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [3:0]     sync1_q, sync2_q;
  state_t         state_q;
  logic [SCW-1:0] sym_cnt_q;
  logic [NCW-1:0] nib_cnt_q;
  logic [3:0]     nib_lo_q;
  logic [7:0]     data_q;
  logic           dv_q, done_q, err_q, busy_q;
  logic           mid_s, stop_ok_s;
`ifdef LASER_RX_CHECKSUM_EN
  logic [7:0]     xor_q;
  logic           chk_ok_q;
`endif

  // Mid-symbol sample point and the stop-symbol verdict.
  always_comb begin
    mid_s = (sym_cnt_q == SYM_LAST);
`ifdef LASER_RX_CHECKSUM_EN
    stop_ok_s = (sync2_q == 4'h0) && chk_ok_q;
`else
    stop_ok_s = (sync2_q == 4'h0);
`endif
  end

  // Two-flop synchronizer for the asynchronous lanes.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 4'h0;
      sync2_q <= 4'h0;
    end else begin
      sync1_q <= lanes;
      sync2_q <= sync1_q;
    end
  end

  // Framing state machine with registered strobes and data.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      sym_cnt_q <= '0;
      nib_cnt_q <= '0;
      nib_lo_q  <= 4'h0;
      data_q    <= 8'h00;
      dv_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef LASER_RX_CHECKSUM_EN
      xor_q     <= 8'h00;
      chk_ok_q  <= 1'b0;
`endif
    end else begin
      dv_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sync2_q == 4'hF) begin
            state_q   <= START;
            sym_cnt_q <= SCW'(1);
            nib_cnt_q <= '0;
            busy_q    <= 1'b1;
`ifdef LASER_RX_CHECKSUM_EN
            xor_q     <= 8'h00;
`endif
          end else begin
            busy_q <= 1'b0;
          end
        end
        START: begin
          if (sync2_q != 4'hF) begin
            state_q   <= IDLE;
            sym_cnt_q <= '0;
            busy_q    <= 1'b0;
          end else if (sym_cnt_q == HALF_LAST) begin
            // Half a start symbol seen: counting a full symbol from here lands mid-nibble.
            state_q   <= DATA;
            sym_cnt_q <= '0;
          end else begin
            sym_cnt_q <= sym_cnt_q + SCW'(1);
          end
        end
        DATA: begin
          if (mid_s) begin
            sym_cnt_q <= '0;
            if (!nib_cnt_q[0]) begin
              nib_lo_q <= sync2_q;
            end else begin
              data_q <= {sync2_q, nib_lo_q};
              dv_q   <= 1'b1;
`ifdef LASER_RX_CHECKSUM_EN
              xor_q  <= xor_q ^ {sync2_q, nib_lo_q};
`endif
            end
            if (nib_cnt_q == NIB_LAST) begin
              nib_cnt_q <= '0;
`ifdef LASER_RX_CHECKSUM_EN
              state_q   <= CHECK;
`else
              state_q   <= STOP;
`endif
            end else begin
              nib_cnt_q <= nib_cnt_q + NCW'(1);
            end
          end else begin
            sym_cnt_q <= sym_cnt_q + SCW'(1);
          end
        end
`ifdef LASER_RX_CHECKSUM_EN
        CHECK: begin
          if (mid_s) begin
            sym_cnt_q <= '0;
            if (!nib_cnt_q[0]) begin
              nib_lo_q  <= sync2_q;
              nib_cnt_q <= NCW'(1);
            end else begin
              chk_ok_q  <= ({sync2_q, nib_lo_q} == xor_q);
              nib_cnt_q <= '0;
              state_q   <= STOP;
            end
          end else begin
            sym_cnt_q <= sym_cnt_q + SCW'(1);
          end
        end
`endif
        STOP: begin
          if (mid_s) begin
            sym_cnt_q <= '0;
            done_q    <= stop_ok_s;
            err_q     <= !stop_ok_s;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end else begin
            sym_cnt_q <= sym_cnt_q + SCW'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          sym_cnt_q <= '0;
          nib_cnt_q <= '0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign data        = data_q;
  assign data_valid  = dv_q;
  assign frame_done  = done_q;
  assign frame_error = err_q;
  assign busy        = busy_q;

endmodule
